// File: rtl/cmul_pkg.sv
// rtl/cmul_pkg.sv - shared widths, rounding constant and overflow direction for cmul_pipe
package cmul_pkg;

  typedef enum logic [1:0] {
    OVF_NONE,
    OVF_POS,
    OVF_NEG
  } ovf_dir_e;

  // One extra bit covers the conj-negated coefficient at COEF_W+1.
  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  function automatic logic [127:0] rnd_const(input int shift);
    logic [127:0] v;
    v = '0;
    if (shift > 0) v[shift-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// rtl/cmul_round_sat.sv - round-half-up, arithmetic shift, range check, wrap or clamp
// CMUL_PIPE_SAT_EN selects clamping on overflow; otherwise the low OUT_W bits are kept.
module cmul_round_sat
  import cmul_pkg::*;
#(
  parameter int IN_W       = 34,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  i_x,
  output logic signed [OUT_W-1:0] o_y,
  output logic                    o_ovf
);
  localparam int EW = IN_W + 1;
  localparam logic [EW-1:0] RND = EW'(rnd_const(FRAC_SHIFT));

  logic signed [EW-1:0]  w_sum;
  logic signed [EW-1:0]  w_sh;
  logic [EW-OUT_W:0]     w_hi;
  ovf_dir_e              w_dir;

  assign w_sum = EW'(i_x) + $signed(RND);
  assign w_sh  = w_sum >>> FRAC_SHIFT;
  assign w_hi  = w_sh[EW-1:OUT_W-1];

  // In range only when every bit from the OUT_W sign bit upward agrees.
  always_comb begin
    w_dir = OVF_NONE;
    if (!w_hi[EW-OUT_W] && (|w_hi)) begin
      w_dir = OVF_POS;
    end else if (w_hi[EW-OUT_W] && !(&w_hi)) begin
      w_dir = OVF_NEG;
    end
  end

  assign o_ovf = (w_dir != OVF_NONE);

`ifdef CMUL_PIPE_SAT_EN
  always_comb begin
    o_y = w_sh[OUT_W-1:0];
    case (w_dir)
      OVF_POS: o_y = {1'b0, {(OUT_W-1){1'b1}}};
      OVF_NEG: o_y = {1'b1, {(OUT_W-1){1'b0}}};
      default: o_y = w_sh[OUT_W-1:0];
    endcase
  end
`else
  assign o_y = w_sh[OUT_W-1:0];
`endif

endmodule

// File: rtl/cmul_pipe.sv
// rtl/cmul_pipe.sv - 3-stage signed complex multiplier, in*w or in*conj(w), valid/ready stream
// CMUL_PIPE_SAT_EN enables output saturation in cmul_round_sat (default: wrap).
module cmul_pipe
  import cmul_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [COEF_W-1:0] w_r,
  input  logic signed [COEF_W-1:0] w_i,
  input  logic                     conj,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_r,
  output logic signed [OUT_W-1:0]  out_i,
  output logic                     out_ovf
);
  localparam int PW = prod_w(DATA_W, COEF_W);
  localparam int SW = PW + 1;

  logic                     w_en;
  logic signed [COEF_W:0]   w_wi_ext;
  logic signed [COEF_W:0]   w_wi_eff;

  logic                     r1_valid;
  logic signed [DATA_W-1:0] r1_in_r;
  logic signed [DATA_W-1:0] r1_in_i;
  logic signed [COEF_W-1:0] r1_w_r;
  logic signed [COEF_W:0]   r1_wi;

  logic                     r2_valid;
  logic signed [PW-1:0]     r2_rr;
  logic signed [PW-1:0]     r2_ii;
  logic signed [PW-1:0]     r2_ri;
  logic signed [PW-1:0]     r2_ir;

  logic signed [SW-1:0]     w_re;
  logic signed [SW-1:0]     w_im;
  logic signed [OUT_W-1:0]  w_re_y;
  logic signed [OUT_W-1:0]  w_im_y;
  logic                     w_re_ovf;
  logic                     w_im_ovf;

  // Whole pipe advances together; a held output freezes every stage.
  assign w_en     = out_ready | ~out_valid;
  assign in_ready = w_en & ~rst;

  assign w_wi_ext = {w_i[COEF_W-1], w_i};
  assign w_wi_eff = conj ? -w_wi_ext : w_wi_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid  <= 1'b0;
      r2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      out_ovf   <= 1'b0;
    end else if (w_en) begin
      r1_valid  <= in_valid;
      r2_valid  <= r1_valid;
      out_valid <= r2_valid;
      out_r     <= w_re_y;
      out_i     <= w_im_y;
      out_ovf   <= w_re_ovf | w_im_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r1_in_r <= in_r;
      r1_in_i <= in_i;
      r1_w_r  <= w_r;
      r1_wi   <= w_wi_eff;
      r2_rr   <= PW'(r1_in_r) * PW'(r1_w_r);
      r2_ii   <= PW'(r1_in_i) * PW'(r1_wi);
      r2_ri   <= PW'(r1_in_r) * PW'(r1_wi);
      r2_ir   <= PW'(r1_in_i) * PW'(r1_w_r);
    end
  end

  assign w_re = SW'(r2_rr) - SW'(r2_ii);
  assign w_im = SW'(r2_ri) + SW'(r2_ir);

  cmul_round_sat #(
    .IN_W      (SW),
    .OUT_W     (OUT_W),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_rs_re (
    .i_x  (w_re),
    .o_y  (w_re_y),
    .o_ovf(w_re_ovf)
  );

  cmul_round_sat #(
    .IN_W      (SW),
    .OUT_W     (OUT_W),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_rs_im (
    .i_x  (w_im),
    .o_y  (w_im_y),
    .o_ovf(w_im_ovf)
  );

endmodule

// File: tb/tb_cmul_pipe.sv
// tb/tb_cmul_pipe.sv - self-checking bench for cmul_pipe against a behavioural complex-multiply model
module tb_cmul_pipe;
  localparam int FS = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_r, in_i, w_r, w_i;
  logic        conj;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r, out_i;
  logic        out_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    logic        o;
  } exp_t;
  exp_t q[$];

  cmul_pipe #(
    .DATA_W(16), .COEF_W(16), .OUT_W(16), .FRAC_SHIFT(FS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .w_r(w_r), .w_i(w_i), .conj(conj),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic void fit(input longint v, output logic [15:0] y, output logic o);
    longint s;
    s = v;
    if (FS > 0) s = s + (longint'(1) <<< (FS - 1));
    s = s >>> FS;
    o = (s > 32767) || (s < -32768);
`ifdef CMUL_PIPE_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    y = s[15:0];
  endfunction

  function automatic exp_t model(input logic [15:0] ar, ai, br, bi, input logic cj);
    longint a_r, a_i, b_r, b_i;
    logic   o_r, o_i;
    exp_t   e;
    a_r = longint'($signed(ar));
    a_i = longint'($signed(ai));
    b_r = longint'($signed(br));
    b_i = longint'($signed(bi));
    if (cj) b_i = -b_i;
    fit(a_r * b_r - a_i * b_i, e.r, o_r);
    fit(a_r * b_i + a_i * b_r, e.i, o_i);
    e.o = o_r | o_i;
    return e;
  endfunction

  logic        p_hold = 1'b0;
  logic [15:0] p_r, p_i;
  logic        p_o;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
    end else begin
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, out_ready | ~out_valid});
      if (p_hold) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_r", {48'd0, out_r}, {48'd0, p_r});
        chk("stall_i", {48'd0, out_i}, {48'd0, p_i});
        chk("stall_ovf", {63'd0, out_ovf}, {63'd0, p_o});
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_r", {48'd0, out_r}, {48'd0, e.r});
          chk("sb_i", {48'd0, out_i}, {48'd0, e.i});
          chk("sb_ovf", {63'd0, out_ovf}, {63'd0, e.o});
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_r, in_i, w_r, w_i, conj));
    end
    p_hold = !rst && out_valid && !out_ready;
    p_r = out_r;
    p_i = out_i;
    p_o = out_ovf;
  end

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic set_in(input logic [15:0] ar, ai, br, bi, input logic cj);
    in_r = ar; in_i = ai; w_r = br; w_i = bi; conj = cj;
  endtask

  // Presents one sample and waits (bounded) until the DUT takes it.
  task automatic push(input logic [15:0] ar, ai, br, bi, input logic cj);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    set_in(ar, ai, br, bi, cj);
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  // Single sample into an empty pipe with out_ready high: check latency and literal result.
  task automatic send_one(input string nm, input logic [15:0] ar, ai, br, bi, input logic cj,
                          input logic [15:0] er, ei, input logic eo);
    int n;
    push(ar, ai, br, bi, cj);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd3);
    chk({nm, "_r"}, {48'd0, out_r}, {48'd0, er});
    chk({nm, "_i"}, {48'd0, out_i}, {48'd0, ei});
    chk({nm, "_ovf"}, {63'd0, out_ovf}, {63'd0, eo});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    logic [15:0] sat_pos;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_in(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
`ifdef CMUL_PIPE_SAT_EN
    sat_pos = 16'h7FFF;
`else
    sat_pos = 16'h8000;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_r", {48'd0, out_r}, 64'd0);
    chk("reset_out_i", {48'd0, out_i}, 64'd0);
    chk("reset_out_ovf", {63'd0, out_ovf}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send_one("q15_half", 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h2000, 16'h0000, 1'b0);
    send_one("imag_imag", 16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b0, 16'hE000, 16'h0000, 1'b0);
    send_one("imag_conj", 16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b1, 16'h2000, 16'h0000, 1'b0);
    send_one("ovf_min_min", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, sat_pos, 16'h0000, 1'b1);
    send_one("round_up", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0001, 16'h0000, 1'b0);
    send_one("round_neg", 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    send_one("conj_min_wi", 16'h0000, 16'h8000, 16'h0000, 16'h8000, 1'b1, sat_pos, 16'h0000, 1'b1);
    send_one("min_wi", 16'h0000, 16'h8000, 16'h0000, 16'h8000, 1'b0, 16'h8000, 16'h0000, 1'b0);

    base = n_out;
    fork
      begin
        for (int k = 0; k < 6; k++) push(rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(n_out - base), 64'd6);

    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push(rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_queue", 64'(q.size()), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("rst_no_stale", {63'd0, out_valid}, 64'd0);
    end
    send_one("after_rst", 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h2000, 16'h0000, 1'b0);

    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      set_in(rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
